// File: rtl/opsum_collector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | opsum_collector_pkg : shared widths, FSM encoding, layer config type  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package opsum_collector_pkg;

  localparam int DEF_DATA_BITS    = 16;
  localparam int DEF_XID_BITS     = 4;
  localparam int DEF_YID_BITS     = 4;
  localparam int OPSUM_FIFO_DEPTH = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_FIN     = 2'd3;

  typedef struct packed {
    logic [2:0] e_last;
    logic [1:0] t_last;
    logic [7:0] pass_last;
    logic       relu;
  } layer_cfg_t;

  // Only every third PE row (2, 5, 8, 11) carries finished partial sums.
  function automatic logic [3:0] row_tag(input logic [1:0] t);
    return ({2'b00, t} * 4'd3) + 4'd2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/opsum_collector_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | opsum_fifo : small register FIFO with count and head-of-queue output  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module opsum_fifo #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int CNT_BITS = $clog2(DEPTH + 1),
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    dout,
  output logic                full,
  output logic                empty,
  output logic [CNT_BITS-1:0] count
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_BITS'(push) - CNT_BITS'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_BITS'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/opsum_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | opsum_collector : gathers PE-array opsums, buffers them, writes GLB   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module opsum_collector
  import opsum_collector_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_BITS,
  parameter int XID_BITS  = DEF_XID_BITS,
  parameter int YID_BITS  = DEF_YID_BITS,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           cfg_e_last,
  input  logic [1:0]           cfg_t_last,
  input  logic [7:0]           cfg_pass_last,
  input  logic [ADDR_BITS-1:0] cfg_base_addr,
  input  logic                 cfg_relu,
  input  logic                 GLB_opsum_valid,
  input  logic [DATA_SIZE-1:0] GLB_data_out,
  output logic                 GLB_opsum_ready,
  output logic [XID_BITS-1:0]  opsum_tag_X,
  output logic [YID_BITS-1:0]  opsum_tag_Y,
  output logic [2:0]           opsum_e_cnt,
  output logic [1:0]           opsum_t_cnt,
  output logic                 op_get_done,
  output logic                 op_pass_done,
  output logic                 glb_wr_en,
  output logic [ADDR_BITS-1:0] glb_wr_addr,
  output logic [DATA_SIZE-1:0] glb_wr_data,
  input  logic                 glb_wr_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_BITS = $clog2(OPSUM_FIFO_DEPTH + 1);

  logic [1:0]           state_q, state_d;
  layer_cfg_t           cfg_q, cfg_d;
  logic [2:0]           e_cnt_q, e_cnt_d;
  logic [1:0]           t_cnt_q, t_cnt_d;
  logic [7:0]           pass_cnt_q, pass_cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;

  logic                 accept, wr_fire, fifo_push;
  logic                 fifo_full, fifo_empty;
  logic [CNT_BITS-1:0]  fifo_count;
  logic [DATA_SIZE-1:0] push_data;

  assign GLB_opsum_ready = (state_q == S_COLLECT) && (fifo_count < CNT_BITS'(OPSUM_FIFO_DEPTH));
  assign accept          = GLB_opsum_valid && GLB_opsum_ready;
  assign fifo_push       = accept && !fifo_full;
  assign glb_wr_en       = !fifo_empty;
  assign wr_fire         = glb_wr_en && glb_wr_ready;
  assign push_data       = (cfg_q.relu && GLB_data_out[DATA_SIZE-1]) ? '0 : GLB_data_out;

  assign op_get_done  = accept && (e_cnt_q == cfg_q.e_last) && (t_cnt_q == cfg_q.t_last);
  assign op_pass_done = op_get_done && (pass_cnt_q == cfg_q.pass_last);

  assign opsum_tag_X = XID_BITS'(e_cnt_q);
  assign opsum_tag_Y = YID_BITS'(row_tag(t_cnt_q));
  assign opsum_e_cnt = e_cnt_q;
  assign opsum_t_cnt = t_cnt_q;
  assign glb_wr_addr = addr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    e_cnt_d    = e_cnt_q;
    t_cnt_d    = t_cnt_q;
    pass_cnt_d = pass_cnt_q;
    addr_d     = wr_fire ? addr_q + 1'b1 : addr_q;

    if (accept) begin
      if (e_cnt_q == cfg_q.e_last) begin
        e_cnt_d = '0;
        if (t_cnt_q == cfg_q.t_last) begin
          t_cnt_d    = '0;
          pass_cnt_d = pass_cnt_q + 1'b1;
        end else begin
          t_cnt_d = t_cnt_q + 1'b1;
        end
      end else begin
        e_cnt_d = e_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d         = S_COLLECT;
          cfg_d.e_last    = cfg_e_last;
          cfg_d.t_last    = cfg_t_last;
          cfg_d.pass_last = cfg_pass_last;
          cfg_d.relu      = cfg_relu;
          e_cnt_d         = '0;
          t_cnt_d         = '0;
          pass_cnt_d      = '0;
          addr_d          = cfg_base_addr;
        end
      end
      S_COLLECT: if (op_pass_done) state_d = S_DRAIN;
      S_DRAIN:   if (fifo_empty)   state_d = S_FIN;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cfg_q      <= '0;
      e_cnt_q    <= '0;
      t_cnt_q    <= '0;
      pass_cnt_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      e_cnt_q    <= e_cnt_d;
      t_cnt_q    <= t_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      addr_q     <= addr_d;
    end
  end

  opsum_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (OPSUM_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (wr_fire),
    .din   (push_data),
    .dout  (glb_wr_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_opsum_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_opsum_collector : layer table + random traffic vs reference model  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_opsum_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  cfg_e_last;
  logic [1:0]  cfg_t_last;
  logic [7:0]  cfg_pass_last;
  logic [15:0] cfg_base_addr;
  logic        cfg_relu;
  logic        GLB_opsum_valid;
  logic [15:0] GLB_data_out;
  logic        GLB_opsum_ready;
  logic [3:0]  opsum_tag_X;
  logic [3:0]  opsum_tag_Y;
  logic [2:0]  opsum_e_cnt;
  logic [1:0]  opsum_t_cnt;
  logic        op_get_done;
  logic        op_pass_done;
  logic        glb_wr_en;
  logic [15:0] glb_wr_addr;
  logic [15:0] glb_wr_data;
  logic        glb_wr_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opsum_collector dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_e_last      (cfg_e_last),
    .cfg_t_last      (cfg_t_last),
    .cfg_pass_last   (cfg_pass_last),
    .cfg_base_addr   (cfg_base_addr),
    .cfg_relu        (cfg_relu),
    .GLB_opsum_valid (GLB_opsum_valid),
    .GLB_data_out    (GLB_data_out),
    .GLB_opsum_ready (GLB_opsum_ready),
    .opsum_tag_X     (opsum_tag_X),
    .opsum_tag_Y     (opsum_tag_Y),
    .opsum_e_cnt     (opsum_e_cnt),
    .opsum_t_cnt     (opsum_t_cnt),
    .op_get_done     (op_get_done),
    .op_pass_done    (op_pass_done),
    .glb_wr_en       (glb_wr_en),
    .glb_wr_addr     (glb_wr_addr),
    .glb_wr_data     (glb_wr_data),
    .glb_wr_ready    (glb_wr_ready),
    .busy            (busy),
    .done            (done)
  );

  // rdy_mode: 0 always ready, 1 random, 2 held low for 10 cycles
  // vld_mode: 0 always valid, 1 random; seq 1 feeds FFF0 then 0012
  typedef struct {
    logic [2:0]  e_last;
    logic [1:0]  t_last;
    logic [7:0]  pass_last;
    logic [15:0] base;
    logic        relu;
    int          rdy_mode;
    int          vld_mode;
    int          glitch;
    int          seq;
    int          exp_acc;
    int          exp_get;
    int          exp_pass;
    logic [15:0] exp_end_addr;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_quiet_outputs(input string tag);
    chk({tag, " ready"},  GLB_opsum_ready, 0);
    chk({tag, " tagX"},   opsum_tag_X, 0);
    chk({tag, " tagY"},   opsum_tag_Y, 2);
    chk({tag, " e_cnt"},  opsum_e_cnt, 0);
    chk({tag, " t_cnt"},  opsum_t_cnt, 0);
    chk({tag, " get"},    op_get_done, 0);
    chk({tag, " pass"},   op_pass_done, 0);
    chk({tag, " wr_en"},  glb_wr_en, 0);
    chk({tag, " addr"},   glb_wr_addr, 0);
    chk({tag, " data"},   glb_wr_data, 0);
    chk({tag, " busy"},   busy, 0);
    chk({tag, " done"},   done, 0);
  endtask

  task automatic drive(input vec_t v, input int k, input int cyc);
    if (v.glitch != 0 && cyc == 3) begin
      start         = 1'b1;
      cfg_base_addr = 16'hDEAD;
      cfg_e_last    = 3'd0;
      cfg_pass_last = 8'd0;
    end else begin
      start = 1'b0;
    end
    GLB_opsum_valid = (v.vld_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (v.seq == 1 && k == 0)      GLB_data_out = 16'hFFF0;
    else if (v.seq == 1 && k == 1) GLB_data_out = 16'h0012;
    else                           GLB_data_out = 16'($urandom);
    case (v.rdy_mode)
      0:       glb_wr_ready = 1'b1;
      1:       glb_wr_ready = $urandom_range(0, 1) != 0;
      default: glb_wr_ready = (cyc >= 10);
    endcase
  endtask

  task automatic run_layer(input vec_t v);
    logic [15:0] q[$];
    int k = 0, wr_idx = 0, cyc = 0, acc_cnt = 0, get_cnt = 0, pass_cnt = 0, done_cnt = 0;
    int ept, total;
    bit collecting, finished;
    logic exp_rdy, acc;
    ept   = (int'(v.e_last) + 1) * (int'(v.t_last) + 1);
    total = ept * (int'(v.pass_last) + 1);
    finished = 0;

    @(posedge clk); #1;
    start = 1'b1; cfg_e_last = v.e_last; cfg_t_last = v.t_last; cfg_pass_last = v.pass_last;
    cfg_base_addr = v.base; cfg_relu = v.relu; GLB_opsum_valid = 1'b0; glb_wr_ready = 1'b1;
    @(posedge clk); #1;
    collecting = 1;
    drive(v, k, cyc);

    while (!finished && cyc < 3000) begin
      @(negedge clk);
      exp_rdy = collecting && (q.size() < 4);
      chk("ready", GLB_opsum_ready, exp_rdy);
      if (collecting) begin
        chk("busy", busy, 1);
        chk("e_cnt", opsum_e_cnt, k % (int'(v.e_last) + 1));
        chk("t_cnt", opsum_t_cnt, (k / (int'(v.e_last) + 1)) % (int'(v.t_last) + 1));
        chk("tagX", opsum_tag_X, k % (int'(v.e_last) + 1));
        chk("tagY", opsum_tag_Y, 3 * ((k / (int'(v.e_last) + 1)) % (int'(v.t_last) + 1)) + 2);
      end
      acc = GLB_opsum_valid && exp_rdy;
      chk("get_done", op_get_done, acc && ((k + 1) % ept == 0));
      chk("pass_done", op_pass_done, acc && (k + 1 == total));
      chk("wr_en", glb_wr_en, q.size() != 0);
      if (q.size() != 0) begin
        chk("wr_data", glb_wr_data, q[0]);
        chk("wr_addr", glb_wr_addr, 16'(v.base + 16'(wr_idx)));
      end
      if (GLB_opsum_valid && GLB_opsum_ready) acc_cnt++;
      if (op_get_done)  get_cnt++;
      if (op_pass_done) pass_cnt++;
      if (done)         done_cnt++;
      if (q.size() != 0 && glb_wr_ready) begin
        void'(q.pop_front());
        wr_idx++;
      end
      if (acc) begin
        q.push_back((v.relu && GLB_data_out[15]) ? 16'h0000 : GLB_data_out);
        k++;
        if (k == total) collecting = 0;
      end
      if (!collecting && q.size() == 0 && !busy && done_cnt > 0) begin
        finished = 1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        drive(v, k, cyc);
      end
    end
    if (!finished) chk("layer_timeout", 1, 0);
    start = 1'b0; GLB_opsum_valid = 1'b0;
    chk("accepts", acc_cnt, v.exp_acc);
    chk("get_pulses", get_cnt, v.exp_get);
    chk("pass_pulses", pass_cnt, v.exp_pass);
    chk("done_pulses", done_cnt, 1);
    chk("end_addr", glb_wr_addr, v.exp_end_addr);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    //        e  t  p   base      relu rdy vld gl seq acc get pass end
    tbl[0] = '{3'd2, 2'd0, 8'd0, 16'h0100, 1'b0, 0, 0, 0, 0,  3, 1, 1, 16'h0103};
    tbl[1] = '{3'd0, 2'd3, 8'd1, 16'h0020, 1'b0, 0, 0, 0, 0,  8, 2, 1, 16'h0028};
    tbl[2] = '{3'd2, 2'd1, 8'd0, 16'h0200, 1'b0, 2, 0, 0, 0,  6, 1, 1, 16'h0206};
    tbl[3] = '{3'd1, 2'd0, 8'd0, 16'h0300, 1'b1, 0, 0, 0, 1,  2, 1, 1, 16'h0302};
    tbl[4] = '{3'd1, 2'd0, 8'd0, 16'h0310, 1'b0, 0, 0, 0, 1,  2, 1, 1, 16'h0312};
    tbl[5] = '{3'd1, 2'd1, 8'd0, 16'hFFFE, 1'b0, 1, 1, 0, 0,  4, 1, 1, 16'h0002};
    tbl[6] = '{3'd3, 2'd2, 8'd0, 16'h0400, 1'b0, 0, 0, 1, 0, 12, 1, 1, 16'h040C};
    tbl[7] = '{3'd7, 2'd3, 8'd2, 16'h1000, 1'b1, 1, 1, 0, 0, 96, 3, 1, 16'h1060};

    rst = 1'b0; start = 1'b0; cfg_e_last = '0; cfg_t_last = '0; cfg_pass_last = '0;
    cfg_base_addr = '0; cfg_relu = 1'b0; GLB_opsum_valid = 1'b0; GLB_data_out = '0;
    glb_wr_ready = 1'b0;
    #1;
    chk_quiet_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 8; i++) run_layer(tbl[i]);

    // Mid-layer reset with two words stranded in the FIFO
    @(posedge clk); #1;
    start = 1'b1; cfg_e_last = 3'd7; cfg_t_last = 2'd3; cfg_pass_last = 8'd0;
    cfg_base_addr = 16'h0500; cfg_relu = 1'b0; glb_wr_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; GLB_opsum_valid = 1'b1; GLB_data_out = 16'h1234;
    repeat (2) @(posedge clk);
    #1 GLB_opsum_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst wr_en", glb_wr_en, 1);
    chk("pre_rst e_cnt", opsum_e_cnt, 2);
    #2 rst = 1'b0;
    #1 chk_quiet_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b1; glb_wr_ready = 1'b1; GLB_opsum_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst wr_en", glb_wr_en, 0);
      chk("post_rst ready", GLB_opsum_ready, 0);
    end
    GLB_opsum_valid = 1'b0;
    run_layer(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
